// File: rtl/pong_pkg.sv
// pong_pkg: shared definitions for the Pong game sequencer.
//   - game_state_t : FSM state encoding, exported on game_state
//   - playfield, paddle and ball geometry constants
//   - reset / serve positions
//   - paddle_move(): one tick of paddle motion, clamped to the playfield
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_SCORE    = 3'd3,
        ST_GAMEOVER = 3'd4
    } game_state_t;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int PADDLE_W    = 8;
    localparam int PADDLE_H    = 64;
    localparam int BALL_SIZE   = 8;
    localparam int P1_X        = 16;
    localparam int P2_X        = 616;
    localparam int PADDLE_STEP = 4;
    localparam int BALL_SPEED  = 2;
    localparam int MAX_SCORE   = 9;

    localparam logic [9:0] PADDLE_Y0 = 10'd208;
    localparam logic [9:0] BALL_X0   = 10'd316;
    localparam logic [9:0] BALL_Y0   = 10'd236;

    // Work at 11 bits so the subtract cannot wrap and the add cannot
    // overflow before the clamp; truncate only after clamping.
    function automatic logic [9:0] paddle_move(input logic [9:0] y,
                                               input logic       up,
                                               input logic       down);
        logic [10:0] y_ext;
        logic [10:0] res;
        y_ext = {1'b0, y};
        res   = y_ext;
        if (up && !down) begin
            res = (y_ext < 11'(PADDLE_STEP)) ? 11'd0 : y_ext - 11'(PADDLE_STEP);
        end else if (down && !up) begin
            res = (y_ext + 11'(PADDLE_STEP) > 11'(SCREEN_H - PADDLE_H)) ?
                  11'(SCREEN_H - PADDLE_H) : y_ext + 11'(PADDLE_STEP);
        end
        return 10'(res);
    endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if: player inputs and game outputs of the Pong sequencer.
//   slave  : the game controller (takes buttons/start, drives coordinates,
//            scores, state and frame_tick)
//   master : the environment (buttons, start) that consumes the outputs
interface pong_game_ctrl_if;

    logic       start;
    logic       p1_up;
    logic       p1_down;
    logic       p2_up;
    logic       p2_down;
    logic [9:0] x1;
    logic [9:0] y1;
    logic [9:0] x2;
    logic [9:0] y2;
    logic [9:0] xb;
    logic [9:0] yb;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [2:0] game_state;
    logic       frame_tick;

    modport master (
        output start, p1_up, p1_down, p2_up, p2_down,
        input  x1, y1, x2, y2, xb, yb, score1, score2, game_state, frame_tick
    );

    modport slave (
        input  start, p1_up, p1_down, p2_up, p2_down,
        output x1, y1, x2, y2, xb, yb, score1, score2, game_state, frame_tick
    );

endinterface

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: free-running divider producing one tick per FRAME_DIV clocks.
//   clk  : clock
//   rst  : synchronous active-high reset (counter to 0)
//   tick : high for the single cycle in which the counter is FRAME_DIV-1
module frame_tick_gen #(
    parameter int FRAME_DIV = 833333
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)       cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == CW'(FRAME_DIV - 1));

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: Pong game sequencer.
//   clock_50MHz : sole clock
//   rst         : synchronous active-high reset
//   bus (slave) : start / paddle buttons in; paddle and ball top-left
//                 corners, scores, game_state and frame_tick out
// All game updates happen on the edge that samples frame_tick=1, except the
// start-edge transitions out of IDLE and GAMEOVER which are taken at once.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int FRAME_DIV   = 833333,
    parameter int SERVE_DELAY = 60
) (
    input  logic              clock_50MHz,
    input  logic              rst,
    pong_game_ctrl_if.slave   bus
);

    localparam int DW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY + 1) : 1;

    localparam logic [10:0] SPD   = 11'(BALL_SPEED);
    localparam logic [10:0] BSZ   = 11'(BALL_SIZE);
    localparam logic [10:0] PH    = 11'(PADDLE_H);
    localparam logic [10:0] L_HIT = 11'(P1_X + PADDLE_W + BALL_SPEED);
    localparam logic [10:0] R_HIT = 11'(P2_X);
    localparam logic [10:0] SW    = 11'(SCREEN_W);
    localparam logic [10:0] SH    = 11'(SCREEN_H);

    logic tick;

    frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
        .clk  (clock_50MHz),
        .rst  (rst),
        .tick (tick)
    );

    game_state_t   state_q, state_d;
    logic [9:0]    y1_q, y1_d, y2_q, y2_d;
    logic [9:0]    xb_q, xb_d, yb_q, yb_d;
    logic          dx_q, dx_d, dy_q, dy_d;   // 1 = increasing coordinate
    logic [3:0]    s1_q, s1_d, s2_q, s2_d;
    logic [DW-1:0] dly_q, dly_d;
    logic          start_q;
    logic          start_rise;
    logic          dly_done;

    // Candidate ball motion for this tick, evaluated from the current
    // (pre-update) ball and paddle positions.
    logic [10:0] xb_ext, yb_ext, y1_ext, y2_ext;
    logic        ov1, ov2;
    logic [9:0]  xb_nx, yb_nx;
    logic        dx_nx, dy_nx;
    logic        miss_l, miss_r;

    assign start_rise = bus.start & ~start_q;
    assign dly_done   = (dly_q == DW'(SERVE_DELAY - 1));

    always_comb begin
        xb_ext = {1'b0, xb_q};
        yb_ext = {1'b0, yb_q};
        y1_ext = {1'b0, y1_q};
        y2_ext = {1'b0, y2_q};
        ov1    = (yb_ext + BSZ > y1_ext) && (yb_ext < y1_ext + PH);
        ov2    = (yb_ext + BSZ > y2_ext) && (yb_ext < y2_ext + PH);

        yb_nx  = yb_q;
        dy_nx  = dy_q;
        if (!dy_q) begin
            if (yb_ext < SPD) begin
                yb_nx = 10'd0;
                dy_nx = 1'b1;
            end else begin
                yb_nx = 10'(yb_ext - SPD);
            end
        end else begin
            if (yb_ext + BSZ + SPD > SH) begin
                yb_nx = 10'(SH - BSZ);
                dy_nx = 1'b0;
            end else begin
                yb_nx = 10'(yb_ext + SPD);
            end
        end

        xb_nx  = xb_q;
        dx_nx  = dx_q;
        miss_l = 1'b0;
        miss_r = 1'b0;
        if (!dx_q) begin
            // Compare xb against the hit line plus speed so nothing underflows.
            if (xb_ext <= L_HIT && ov1) begin
                xb_nx = 10'(P1_X + PADDLE_W);
                dx_nx = 1'b1;
            end else if (xb_ext < SPD) begin
                miss_l = 1'b1;
            end else begin
                xb_nx = 10'(xb_ext - SPD);
            end
        end else begin
            if (xb_ext + BSZ + SPD >= R_HIT && ov2) begin
                xb_nx = 10'(P2_X - BALL_SIZE);
                dx_nx = 1'b0;
            end else if (xb_ext + BSZ + SPD > SW) begin
                miss_r = 1'b1;
            end else begin
                xb_nx = 10'(xb_ext + SPD);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        y1_d    = y1_q;
        y2_d    = y2_q;
        xb_d    = xb_q;
        yb_d    = yb_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        dly_d   = dly_q;

        case (state_q)
            ST_IDLE: begin
                if (start_rise) state_d = ST_SERVE;
            end

            ST_SERVE: begin
                if (tick) begin
                    y1_d = paddle_move(y1_q, bus.p1_up, bus.p1_down);
                    y2_d = paddle_move(y2_q, bus.p2_up, bus.p2_down);
                    if (dly_done) state_d = ST_PLAY;
                    else          dly_d   = dly_q + DW'(1);
                end
            end

            ST_PLAY: begin
                if (tick) begin
                    y1_d = paddle_move(y1_q, bus.p1_up, bus.p1_down);
                    y2_d = paddle_move(y2_q, bus.p2_up, bus.p2_down);
                    yb_d = yb_nx;
                    dy_d = dy_nx;
                    // On a miss xb and dx stay put: dx still points at the
                    // player who conceded, which is where the next serve goes.
                    if (miss_l) begin
                        s2_d    = s2_q + 4'd1;
                        state_d = ST_SCORE;
                    end else if (miss_r) begin
                        s1_d    = s1_q + 4'd1;
                        state_d = ST_SCORE;
                    end else begin
                        xb_d = xb_nx;
                        dx_d = dx_nx;
                    end
                end
            end

            ST_SCORE: begin
                if (tick) begin
                    if (dly_done) begin
                        if (s1_q == 4'(MAX_SCORE) || s2_q == 4'(MAX_SCORE)) begin
                            state_d = ST_GAMEOVER;
                        end else begin
                            state_d = ST_SERVE;
                            xb_d    = BALL_X0;
                            yb_d    = BALL_Y0;
                        end
                    end else begin
                        dly_d = dly_q + DW'(1);
                    end
                end
            end

            ST_GAMEOVER: begin
                if (start_rise) begin
                    s1_d    = 4'd0;
                    s2_d    = 4'd0;
                    y1_d    = PADDLE_Y0;
                    y2_d    = PADDLE_Y0;
                    xb_d    = BALL_X0;
                    yb_d    = BALL_Y0;
                    dx_d    = 1'b1;
                    state_d = ST_SERVE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Every state starts its delay count from zero.
        if (state_d != state_q) dly_d = '0;
    end

    always_ff @(posedge clock_50MHz) begin
        if (rst) begin
            state_q <= ST_IDLE;
            y1_q    <= PADDLE_Y0;
            y2_q    <= PADDLE_Y0;
            xb_q    <= BALL_X0;
            yb_q    <= BALL_Y0;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            s1_q    <= 4'd0;
            s2_q    <= 4'd0;
            dly_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            y1_q    <= y1_d;
            y2_q    <= y2_d;
            xb_q    <= xb_d;
            yb_q    <= yb_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            dly_q   <= dly_d;
            start_q <= bus.start;
        end
    end

    assign bus.x1         = 10'(P1_X);
    assign bus.x2         = 10'(P2_X);
    assign bus.y1         = y1_q;
    assign bus.y2         = y2_q;
    assign bus.xb         = xb_q;
    assign bus.yb         = yb_q;
    assign bus.score1     = s1_q;
    assign bus.score2     = s2_q;
    assign bus.game_state = state_q;
    assign bus.frame_tick = tick;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: random button/start stimulus against a per-cycle
// behavioural model of the game rules (signed velocities, integer positions).
module tb_pong_game_ctrl;
    import pong_pkg::*;

    localparam int FDIV = 4;
    localparam int SD   = 2;
    localparam int MAXC = 60000;

    logic clock_50MHz = 1'b0;
    logic rst;

    pong_game_ctrl_if bus();

    pong_game_ctrl #(.FRAME_DIV(FDIV), .SERVE_DELAY(SD)) dut (
        .clock_50MHz (clock_50MHz),
        .rst         (rst),
        .bus         (bus)
    );

    always #5 clock_50MHz = ~clock_50MHz;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_chk++;
        if (obs !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Model state
    int m_state, m_y1, m_y2, m_xb, m_yb, m_vx, m_vy, m_s1, m_s2;
    int m_cnt, m_ticks, m_conceder;
    bit m_startq;

    task automatic m_reset();
        m_state = int'(ST_IDLE);
        m_y1 = 208; m_y2 = 208; m_xb = 316; m_yb = 236;
        m_vx = 2;   m_vy = 2;   m_s1 = 0;   m_s2 = 0;
        m_cnt = 0;  m_ticks = 0; m_startq = 0; m_conceder = 0;
    endtask

    function automatic int pmove(int y, bit up, bit dn);
        int ny;
        ny = y + (dn ? 4 : 0) - (up ? 4 : 0);
        if (ny < 0)   ny = 0;
        if (ny > 416) ny = 416;
        return ny;
    endfunction

    task automatic m_goto(input int st);
        m_state = st;
        m_ticks = 0;
    endtask

    task automatic m_step(input bit r, input bit st, input bit u1, input bit d1,
                          input bit u2, input bit d2);
        bit tick, rise, ov1, ov2, miss;
        int nx, ny;
        if (r) begin
            m_reset();
            return;
        end
        tick     = (m_cnt == FDIV - 1);
        m_cnt    = tick ? 0 : m_cnt + 1;
        rise     = st && !m_startq;
        m_startq = st;
        case (m_state)
            int'(ST_IDLE): if (rise) m_goto(int'(ST_SERVE));
            int'(ST_SERVE): if (tick) begin
                m_y1 = pmove(m_y1, u1, d1);
                m_y2 = pmove(m_y2, u2, d2);
                m_ticks++;
                if (m_ticks == SD) m_goto(int'(ST_PLAY));
            end
            int'(ST_PLAY): if (tick) begin
                ov1  = (m_yb + 8 > m_y1) && (m_yb < m_y1 + 64);
                ov2  = (m_yb + 8 > m_y2) && (m_yb < m_y2 + 64);
                miss = 0;
                ny = m_yb + m_vy;
                if (ny < 0)            begin ny = 0;   m_vy = -m_vy; end
                else if (ny + 8 > 480) begin ny = 472; m_vy = -m_vy; end
                nx = m_xb + m_vx;
                if (m_vx < 0) begin
                    if (nx <= 24 && ov1) begin nx = 24; m_vx = 2; end
                    else if (nx < 0)     begin miss = 1; m_conceder = 1; end
                end else begin
                    if (nx + 8 >= 616 && ov2) begin nx = 608; m_vx = -2; end
                    else if (nx + 8 > 640)    begin miss = 1; m_conceder = 2; end
                end
                m_yb = ny;
                if (miss) begin
                    if (m_conceder == 1) m_s2++; else m_s1++;
                    m_goto(int'(ST_SCORE));
                end else begin
                    m_xb = nx;
                end
                m_y1 = pmove(m_y1, u1, d1);
                m_y2 = pmove(m_y2, u2, d2);
            end
            int'(ST_SCORE): if (tick) begin
                m_ticks++;
                if (m_ticks == SD) begin
                    if (m_s1 == 9 || m_s2 == 9) begin
                        m_goto(int'(ST_GAMEOVER));
                    end else begin
                        m_goto(int'(ST_SERVE));
                        m_xb = 316; m_yb = 236;
                        m_vx = (m_conceder == 1) ? -2 : 2;
                    end
                end
            end
            int'(ST_GAMEOVER): if (rise) begin
                m_s1 = 0; m_s2 = 0; m_y1 = 208; m_y2 = 208;
                m_xb = 316; m_yb = 236; m_vx = 2;
                m_goto(int'(ST_SERVE));
            end
            default: ;
        endcase
    endtask

    initial begin
        bit seen_go, restarted, rst_done;
        int tail, play_cyc;
        seen_go = 0; restarted = 0; rst_done = 0; tail = 0; play_cyc = 0;
        rst = 1'b1;
        bus.start = 0; bus.p1_up = 0; bus.p1_down = 0; bus.p2_up = 0; bus.p2_down = 0;
        m_reset();
        repeat (3) @(posedge clock_50MHz);

        for (int cyc = 0; cyc < MAXC; cyc++) begin
            @(negedge clock_50MHz);
            chk("state",  32'(bus.game_state), m_state);
            chk("x1",     32'(bus.x1), 16);
            chk("x2",     32'(bus.x2), 616);
            chk("y1",     32'(bus.y1), m_y1);
            chk("y2",     32'(bus.y2), m_y2);
            chk("xb",     32'(bus.xb), m_xb);
            chk("yb",     32'(bus.yb), m_yb);
            chk("score1", 32'(bus.score1), m_s1);
            chk("score2", 32'(bus.score2), m_s2);
            chk("tick",   32'(bus.frame_tick), (m_cnt == FDIV - 1) ? 1 : 0);
            if (n_fail > 40) break;
            if (restarted) begin
                tail++;
                if (tail > 200) break;
            end

            rst = 1'b0;
            if (m_state == int'(ST_PLAY)) play_cyc++;
            if (!rst_done && play_cyc == 400) begin
                rst = 1'b1;
                rst_done = 1;
            end
            if ($urandom_range(15) == 0) bus.p1_up   = 1'($urandom_range(1));
            if ($urandom_range(15) == 0) bus.p1_down = 1'($urandom_range(1));
            if ($urandom_range(15) == 0) bus.p2_up   = 1'($urandom_range(1));
            if ($urandom_range(15) == 0) bus.p2_down = 1'($urandom_range(1));
            if ($urandom_range(39) == 0) bus.start   = ~bus.start;

            m_step(rst, bus.start, bus.p1_up, bus.p1_down, bus.p2_up, bus.p2_down);
            if (m_state == int'(ST_GAMEOVER)) seen_go = 1;
            if (seen_go && m_state == int'(ST_SERVE)) restarted = 1;
        end

        // A game that never reached GAMEOVER and restarted means the cycle
        // budget ran out.
        chk("game_complete", 32'(restarted), 1);
        chk("mid_play_reset", 32'(rst_done), 1);
        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Hardware game sequencer for the Pong design: it turns player buttons into paddle motion, moves the ball, resolves collisions and keeps score. It drives the paddle and ball coordinates consumed by `vgaDriver` (`x1`/`y1`, `x2`/`y2`, `xb`/`yb`) and exports scores and state for the LCD/status path. It runs once per frame tick from an internal divider; everything else is clocked on `clock_50MHz`.

## Interface
- `SCREEN_W`, 640: playfield width, pixels.
- `SCREEN_H`, 480: playfield height, pixels.
- `PADDLE_W` / `PADDLE_H`, 8 / 64: paddle size.
- `BALL_SIZE`, 8: ball square side.
- `P1_X` / `P2_X`, 16 / 616: fixed paddle left edges.
- `PADDLE_STEP`, 4: paddle pixels per tick.
- `BALL_SPEED`, 2: ball pixels per tick, per axis.
- `FRAME_DIV`, 833333: clocks per tick (60 Hz).
- `SERVE_DELAY`, 60: ticks held in SERVE and SCORE.
- `MAX_SCORE`, 9: points that end the game.
- `clock_50MHz`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level, active-high, already debounced; rising edge used.
- `p1_up`, `p1_down`, `p2_up`, `p2_down`  in  1 each  active-high buttons.
- `x1`, `y1`, `x2`, `y2`  out  10 each  paddle top-left corners.
- `xb`, `yb`  out  10 each  ball top-left corner.
- `score1`, `score2`  out  4 each  points.
- `game_state`  out  3  encoded FSM state.
- `frame_tick`  out  1  one-cycle pulse per tick.

## Operation
- States: IDLE, SERVE, PLAY, SCORE, GAMEOVER.
- Reset: state IDLE; `x1`=16, `x2`=616, `y1`=`y2`=208; `xb`=316, `yb`=236; scores 0; dx=+, dy=+; tick counter 0, `frame_tick`=0; delay counter 0.
- IDLE: start edge -> SERVE.
- SERVE: ball at (316,236). After SERVE_DELAY ticks -> PLAY.
- Paddles, on each tick in SERVE and PLAY only:
  - up moves y by −PADDLE_STEP, clamped at 0.
  - down moves y by +PADDLE_STEP, clamped at SCREEN_H−PADDLE_H (416).
  - Both pressed, or neither: no move.
- Ball, on each tick in PLAY, using the current (pre-update) paddle y:
  - Vertical: dy− and `yb`<BALL_SPEED -> `yb`=0, dy flips. dy+ and `yb`+BALL_SIZE+BALL_SPEED>SCREEN_H -> `yb`=472, dy flips. Otherwise `yb`±BALL_SPEED.
  - Left side: dx− and `xb`−BALL_SPEED ≤ P1_X+PADDLE_W, with overlap (`yb`+BALL_SIZE>`y1` and `yb`<`y1`+PADDLE_H) -> `xb`=24, dx flips.
  - Left miss: dx− and `xb`<BALL_SPEED without overlap -> `score2`+1, go to SCORE.
  - Right side mirrors this: hit test `xb`+BALL_SIZE+BALL_SPEED ≥ P2_X, bounce sets `xb`=608; miss when `xb`+BALL_SIZE+BALL_SPEED>SCREEN_W -> `score1`+1.
  - Otherwise `xb`±BALL_SPEED.
  - Corner case: vertical and horizontal resolve independently in the same tick.
- SCORE: ball frozen. After SERVE_DELAY ticks:
  - a score equal to MAX_SCORE -> GAMEOVER;
  - otherwise -> SERVE, with dx pointed toward the player who conceded; dy is kept.
- GAMEOVER: everything frozen. Start edge clears scores, recentres paddles and ball, sets dx=+, -> SERVE.
- Start edges in SERVE, PLAY and SCORE are ignored.

## Timing
- `frame_tick` is high for exactly one cycle when the tick counter = FRAME_DIV−1; the counter then wraps to 0. It free-runs in every state.
- Position, score and state updates are registered on the same edge that samples `frame_tick`=1. Outputs are visible one cycle after the tick pulse.
- Start edge detection uses a registered copy of `start`. The transition is taken on the edge the rise is detected, not gated by a tick.
- The delay counter clears on every state entry and counts ticks only.
- `rst` mid-game restores all reset values on the next edge; no partial updates.
- All arithmetic is done at 11 bits to avoid underflow and overflow; results are truncated to 10 bits only after clamping.

## Structure
- Package `pong_pkg`: state encoding, default screen, paddle and ball constants, and reset positions (208, 316, 236).
- Sub-module `frame_tick_gen` (parameter FRAME_DIV): counter plus pulse.
- Remainder is a single FSM plus the paddle and ball datapath, about 250 lines.

## Test plan
All scenarios use FRAME_DIV=4 and SERVE_DELAY=2.
- Reset, then start pulse -> SERVE; after 2 ticks, PLAY; ball moves (318,238), then (320,240).
- Hold `p1_up` from `y1`=8 for 3 ticks -> `y1` reads 4, 0, 0. Hold `p2_up`+`p2_down` -> `y2` unchanged.
- Ball at `xb`=26, `yb`=200, dx−, `y1`=180 -> next tick `xb`=24, dx+. Same setup with `y1`=300 -> ball continues to the left edge, `score2`=1, SCORE, then SERVE with dx−.
- Ball `yb`=471 moving down -> `yb`=472, dy−. `yb`=1 moving up -> `yb`=0, dy+.
- `score1`=8, P1 wins a point -> `score1`=9, SCORE, then GAMEOVER; start pulse -> scores 0, SERVE.
- Assert `rst` during PLAY -> next cycle all outputs equal reset values; start edge during PLAY -> no state change.
